// File: rtl/vcpu_bus_pkg.sv
// vcpu_bus_pkg: bus size encodings, FSM states and byte-lane helpers shared by the VCPU memory responder.
package vcpu_bus_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_WORD = 2'd1, SZ_LONG = 2'd2, SZ_RSV = 2'd3} size_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_e;
  // Lane 3 is RAM bits [31:24], which holds byte offset 0 (big-endian).
  function automatic logic [3:0] lane_mask(size_e sz, logic [1:0] off);
    return sz == SZ_BYTE ? 4'b1000 >> off : sz == SZ_WORD ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  endfunction
  function automatic logic [31:0] steer(size_e sz, logic [31:0] d);
    return sz == SZ_BYTE ? {4{d[7:0]}} : sz == SZ_WORD ? {2{d[15:0]}} : d;
  endfunction
  function automatic logic [31:0] rjust(size_e sz, logic [1:0] off, logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {~off, 3'b000};
    return sz == SZ_BYTE ? {24'b0, sh[7:0]} : sz == SZ_WORD ? {16'b0, off[1] ? d[15:0] : d[31:16]} : d;
  endfunction
endpackage

// File: rtl/vcpu_mem_responder_if.sv
// vcpu_mem_responder_if: VCPU bus cycle signals between initiator (master) and memory target (slave).
interface vcpu_mem_responder_if;
  logic        in_REQ;
  logic        in_RW;
  logic [31:0] in_ADDR;
  logic [1:0]  in_SIZE;
  logic [31:0] in_WDATA;
  logic        out_ACK;
  logic        out_BERR;
  logic [31:0] out_RDATA;
  modport master(output in_REQ, in_RW, in_ADDR, in_SIZE, in_WDATA, input out_ACK, out_BERR, out_RDATA);
  modport slave(input in_REQ, in_RW, in_ADDR, in_SIZE, in_WDATA, output out_ACK, out_BERR, out_RDATA);
endinterface

// File: rtl/vcpu_bus_ram.sv
// vcpu_bus_ram: single-port longword RAM with byte write enables and registered read, no reset.
module vcpu_bus_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [3:0]            we_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] rdata_q;
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (we_i[i]) mem[addr_i][8*i+:8] <= wdata_i[8*i+:8];
    rdata_q <= mem[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/vcpu_mem_responder.sv
// vcpu_mem_responder: VCPU bus target with on-chip RAM, address/size/alignment fault decode and wait states.
module vcpu_mem_responder
  import vcpu_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 2
) (
  input logic                 in_CLK,
  input logic                 in_RESET,
  vcpu_mem_responder_if.slave bus
);
  localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;
  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  ack_q, berr_q, rw_q;
  size_e                 size_q, size_in;
  logic [1:0]            lane_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [3:0]            mask_q;
  logic [31:0]           wdata_q, off, ram_rdata;
  logic                  fault;
  always_comb begin
    off     = bus.in_ADDR - ADDR_BASE;
    size_in = size_e'(bus.in_SIZE);
    fault   = size_in == SZ_RSV || (size_in == SZ_WORD && off[0]) ||
              (size_in == SZ_LONG && off[1:0] != 2'b00) || {1'b0, off} >= SPAN;
  end
  always_ff @(posedge in_CLK) begin
    if (in_RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      berr_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.in_REQ) begin
          rw_q    <= bus.in_RW;
          size_q  <= size_in;
          lane_q  <= off[1:0];
          idx_q   <= off[DEPTH_LOG2+1:2];
          mask_q  <= lane_mask(size_in, off[1:0]);
          wdata_q <= steer(size_in, bus.in_WDATA);
          if (fault) begin
            state_q <= S_RESP;
            berr_q  <= 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_q <= S_RESP;
            ack_q   <= 1'b1;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= 4'(WAIT_STATES - 1);
          end
        end
        S_WAIT: if (cnt_q == 4'd0) begin
          state_q <= S_RESP;
          ack_q   <= 1'b1;
        end else cnt_q <= cnt_q - 4'd1;
        S_RESP: state_q <= S_HOLD;
        S_HOLD: if (!bus.in_REQ) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  // IDLE addresses the RAM straight from the bus so read data is ready even with zero wait states.
  vcpu_bus_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk_i  (in_CLK),
    .addr_i (state_q == S_IDLE ? off[DEPTH_LOG2+1:2] : idx_q),
    .we_i   ({4{state_q == S_RESP && ack_q && !rw_q && !in_RESET}} & mask_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );
  assign bus.out_ACK   = ack_q;
  assign bus.out_BERR  = berr_q;
  assign bus.out_RDATA = (ack_q && rw_q) ? rjust(size_q, lane_q, ram_rdata) : 32'h0;
endmodule

// File: tb/tb_vcpu_mem_responder.sv
// tb_vcpu_mem_responder: checks two responders (2 and 0 wait states) against a byte-array memory model.
module tb_vcpu_mem_responder;
  logic        in_CLK = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        sel = 1'b0, req = 1'b0, rw = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  size = '0;
  logic        ack, berr;
  logic [31:0] rdata;
  int          n_chk = 0, n_fail = 0;
  logic [7:0]  mem_m [2][4096];

  vcpu_mem_responder_if ba();
  vcpu_mem_responder_if bb();
  assign ba.in_REQ = req && !sel;
  assign bb.in_REQ = req && sel;
  assign ba.in_RW = rw;
  assign bb.in_RW = rw;
  assign ba.in_ADDR = addr;
  assign bb.in_ADDR = addr;
  assign ba.in_SIZE = size;
  assign bb.in_SIZE = size;
  assign ba.in_WDATA = wdata;
  assign bb.in_WDATA = wdata;
  assign ack   = sel ? bb.out_ACK : ba.out_ACK;
  assign berr  = sel ? bb.out_BERR : ba.out_BERR;
  assign rdata = sel ? bb.out_RDATA : ba.out_RDATA;

  vcpu_mem_responder #(.ADDR_BASE(32'h0), .DEPTH_LOG2(10), .WAIT_STATES(2)) dut_a (
    .in_CLK(in_CLK), .in_RESET(rst_a), .bus(ba));
  vcpu_mem_responder #(.ADDR_BASE(32'h0), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut_b (
    .in_CLK(in_CLK), .in_RESET(rst_b), .bus(bb));

  always #5 in_CLK = ~in_CLK;

  function automatic logic [31:0] mread(bit s, logic [31:0] a, logic [1:0] sz);
    logic [11:0] i = a[11:0];
    case (sz)
      2'd0:    return {24'h0, mem_m[s][i]};
      2'd1:    return {16'h0, mem_m[s][i], mem_m[s][i+1]};
      default: return {mem_m[s][i], mem_m[s][i+1], mem_m[s][i+2], mem_m[s][i+3]};
    endcase
  endfunction

  task automatic mwrite(bit s, logic [31:0] a, logic [1:0] sz, logic [31:0] d);
    logic [11:0] i = a[11:0];
    case (sz)
      2'd0: mem_m[s][i] = d[7:0];
      2'd1: begin mem_m[s][i] = d[15:8]; mem_m[s][i+1] = d[7:0]; end
      default: begin
        mem_m[s][i] = d[31:24]; mem_m[s][i+1] = d[23:16];
        mem_m[s][i+2] = d[15:8]; mem_m[s][i+3] = d[7:0];
      end
    endcase
  endtask

  // k counts negedges from the cycle before the accept edge; k=1 is the cycle after accept.
  task automatic observe(input int exp_k, input bit exp_err, input bit chk_rd, input logic [31:0] exp_rd, input string nm);
    int first = -1;
    int n = 0;
    bit wrong = 0, stray = 0;
    logic [31:0] rd = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge in_CLK);
      if (ack || berr) begin
        n++;
        if (first < 0) first = k;
      end
      if ((ack && berr) || (exp_err ? ack : berr)) wrong = 1;
      if (ack) rd = rdata;
      else if (rdata !== 32'h0) stray = 1;
      if (k == 1) begin
        wdata = $urandom;
        addr  = 32'h3F0;
      end
    end
    @(posedge in_CLK);
    #1 req = 1'b0;
    n_chk++;
    if (first != exp_k || n != 1) begin
      n_fail++;
      $display("FAIL %s timing: response at cycle %0d count %0d, required cycle %0d count 1", nm, first, n, exp_k);
    end
    n_chk++;
    if (wrong) begin
      n_fail++;
      $display("FAIL %s kind: wrong ACK/BERR seen, required %s", nm, exp_err ? "BERR only" : "ACK only");
    end
    n_chk++;
    if (stray) begin
      n_fail++;
      $display("FAIL %s rdata_idle: nonzero RDATA outside ACK, required 0", nm);
    end
    if (chk_rd) begin
      n_chk++;
      if (rd !== exp_rd) begin
        n_fail++;
        $display("FAIL %s rdata: got %h, required %h", nm, rd, exp_rd);
      end
    end
  endtask

  task automatic do_cycle(input bit s, input bit r, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd, input string nm);
    bit f = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a >= 32'h1000;
    logic [31:0] exp_rd = (!f && r) ? mread(s, a, sz) : 32'h0;
    @(posedge in_CLK);
    #1;
    sel = s; rw = r; addr = a; size = sz; wdata = wd; req = 1'b1;
    observe(f ? 1 : (s ? 1 : 3), f, r && !f, exp_rd, nm);
    if (!f && !r) mwrite(s, a, sz, wd);
  endtask

  task automatic test_reset;
    sel = 0; rw = 0; addr = 32'h100; size = 2'd2; wdata = 32'h1122_3344; req = 1'b1;
    repeat (2) begin
      @(posedge in_CLK);
      @(negedge in_CLK);
      n_chk++;
      if (ba.out_ACK !== 1'b0 || ba.out_BERR !== 1'b0 || ba.out_RDATA !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: ack=%b berr=%b rdata=%h, required 0 0 0", ba.out_ACK, ba.out_BERR, ba.out_RDATA);
      end
    end
    @(posedge in_CLK);
    #1 rst_a = 1'b0; rst_b = 1'b0;
    observe(3, 0, 0, 32'h0, "reset_first_write");
    mwrite(0, 32'h100, 2'd2, 32'h1122_3344);
  endtask

  task automatic test_long_rw;
    do_cycle(0, 1, 32'h100, 2'd2, 0, "long_read");
  endtask

  task automatic test_byte_lanes;
    do_cycle(0, 0, 32'h101, 2'd0, 32'h0000_00AB, "byte_write");
    do_cycle(0, 1, 32'h100, 2'd2, 0, "long_read_merged");
    do_cycle(0, 1, 32'h102, 2'd1, 0, "word_read");
    do_cycle(0, 1, 32'h103, 2'd0, 0, "byte_read");
    n_chk++;
    if (mread(0, 32'h100, 2'd2) !== 32'h11AB_3344) begin
      n_fail++;
      $display("FAIL model_sanity: got %h, required 11ab3344", mread(0, 32'h100, 2'd2));
    end
  endtask

  task automatic test_faults;
    do_cycle(0, 0, 32'h101, 2'd1, 32'hFFFF, "word_misaligned");
    do_cycle(0, 1, 32'h102, 2'd2, 0, "long_misaligned");
    do_cycle(0, 1, 32'h100, 2'd3, 0, "size_reserved");
    do_cycle(0, 1, 32'h1000, 2'd2, 0, "out_of_range");
    do_cycle(0, 1, 32'h100, 2'd2, 0, "after_faults");
  endtask

  task automatic test_reset_wait;
    do_cycle(0, 0, 32'h200, 2'd2, 32'h0BAD_F00D, "prior_write");
    @(posedge in_CLK);
    #1;
    sel = 0; rw = 0; addr = 32'h200; size = 2'd2; wdata = 32'hDEAD_BEEF; req = 1'b1;
    @(posedge in_CLK);
    #1 rst_a = 1'b1;
    @(negedge in_CLK);
    @(posedge in_CLK);
    #1 rst_a = 1'b0; req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge in_CLK);
      n_chk++;
      if (ack !== 1'b0 || berr !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_wait_resp: ack=%b berr=%b, required 0 0", ack, berr);
      end
    end
    do_cycle(0, 1, 32'h200, 2'd2, 0, "reset_wait_readback");
  endtask

  task automatic test_zero_wait;
    do_cycle(1, 0, 32'h200, 2'd2, 32'hDEAD_BEEF, "zw_write");
    do_cycle(1, 1, 32'h200, 2'd2, 0, "zw_read");
    do_cycle(1, 0, 32'h203, 2'd0, 32'h5A, "zw_byte_write");
    do_cycle(1, 1, 32'h202, 2'd1, 0, "zw_word_read");
    do_cycle(1, 1, 32'h202, 2'd2, 0, "zw_fault");
  endtask

  task automatic test_random;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++)
        do_cycle(s[0], 0, 32'h300 + 32'(4 * i), 2'd2, $urandom, "rnd_fill");
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 255) : 32'h300 + $urandom_range(0, 63);
        do_cycle(s[0], $urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)), $urandom, "rnd_op");
      end
    end
  endtask

  initial begin
    test_reset();
    test_long_rw();
    test_byte_lanes();
    test_faults();
    test_reset_wait();
    test_zero_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
